ex_mem_stage: RTL and testbench

- EX/MEM pipeline boundary of the 5-stage RISC-V core.
- Captures the ALU result and the EX-stage control/data bundle on each enabled clock edge.
- Resolves branches and jumps from the ALU compare result, and emits a one-shot PC redirect.
- Pre-computes store byte lanes and a misalignment flag for the data-memory stage.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/store_align.sv | 25 ++
 rtl/ex_mem_stage.sv | 101 ++++++++++
 tb/tb_ex_mem_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and constants for the EX/MEM boundary
package pipe_pkg;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_mem_ctrl_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/store_align.sv
// store_align: byte-lane enables, lane-replicated store data and misalignment detect
module store_align
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misaligned
);
  logic [3:0] lanes;
  assign misaligned = (mem_read | mem_write) &
                      (((size == SZ_HALF) & addr[0]) | ((size == SZ_WORD) & (addr != 2'b00)));
  assign lanes = (size == SZ_BYTE) ? 4'b0001 << addr :
                 (size == SZ_HALF) ? 4'b0011 << addr : 4'b1111;
  // a misaligned access must not touch memory, so its lanes are suppressed
  assign be = misaligned ? 4'b0000 : mem_read ? 4'b1111 : lanes;
  assign wdata = (size == SZ_BYTE) ? {(DATA_WIDTH/8){rs2[7:0]}} :
                 (size == SZ_HALF) ? {(DATA_WIDTH/16){rs2[15:0]}} : rs2;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution, one-shot redirect
// and store lane pre-computation
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_pc,
  input  logic [DATA_WIDTH-1:0]     ex_imm,
  input  logic [DATA_WIDTH-1:0]     ex_rs1,
  input  logic [DATA_WIDTH-1:0]     ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [2:0]                ex_funct3,
  input  logic                      ex_branch,
  input  logic                      ex_jal,
  input  logic                      ex_jalr,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_mem_to_reg,
  output logic                      mem_valid,
  output logic [DATA_WIDTH-1:0]     mem_result,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [3:0]                mem_be,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [2:0]                mem_funct3,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      mem_mem_to_reg,
  output logic                      mem_misaligned,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc
);
  ex_mem_ctrl_t          ctrl_d, ctrl_q;
  logic                  taken, taken_q, issued_q, misaligned;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata, jalr_sum, target, result_d;
  store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size      (ex_funct3[1:0]),
    .addr      (alu_result[1:0]),
    .rs2       (ex_rs2),
    .mem_read  (ctrl_d.mem_read),
    .mem_write (ex_valid & ex_mem_write),
    .be        (be),
    .wdata     (wdata),
    .misaligned(misaligned)
  );
  always_comb begin
    ctrl_d.reg_write  = ex_valid & ex_reg_write;
    ctrl_d.mem_read   = ex_valid & ex_mem_read;
    ctrl_d.mem_write  = ex_valid & ex_mem_write & ~misaligned;
    ctrl_d.mem_to_reg = ex_valid & ex_mem_to_reg;
  end
  assign taken    = ex_valid & (ex_jal | ex_jalr | (ex_branch & alu_result[0]));
  assign jalr_sum = ex_rs1 + ex_imm;
  assign target   = ex_jalr ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : ex_pc + ex_imm;
  assign result_d = (ex_jal | ex_jalr) ? ex_pc + DATA_WIDTH'(PC_STEP) : alu_result;
  // issued_q keeps a stalled taken instruction from redirecting more than once
  assign redirect_valid = mem_valid & taken_q & ~issued_q;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_read   = ctrl_q.mem_read;
  assign mem_mem_write  = ctrl_q.mem_write;
  assign mem_mem_to_reg = ctrl_q.mem_to_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      mem_rd         <= '0;
      mem_funct3     <= '0;
      ctrl_q         <= '0;
      mem_misaligned <= 1'b0;
      taken_q        <= 1'b0;
      redirect_pc    <= '0;
      issued_q       <= 1'b0;
    end else if (stall) begin
      issued_q <= issued_q | redirect_valid;
    end else begin
      mem_valid      <= ex_valid;
      mem_result     <= result_d;
      mem_wdata      <= wdata;
      mem_be         <= be;
      mem_rd         <= ex_rd;
      mem_funct3     <= ex_funct3;
      ctrl_q         <= ctrl_d;
      mem_misaligned <= misaligned;
      taken_q        <= taken;
      redirect_pc    <= target;
      issued_q       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors with a queue-based scoreboard for ex_mem_stage
module tb_ex_mem_stage;
  logic        clk, reset, stall, flush, ex_valid;
  logic [31:0] alu_result, ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_branch, ex_jal, ex_jalr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic        mem_misaligned, redirect_valid;
  logic [31:0] mem_result, mem_wdata, redirect_pc;
  logic [3:0]  mem_be;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;

  typedef struct packed {
    logic        v;
    logic [31:0] res, wd;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mr, mw, m2r, mis, rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_misaligned(mem_misaligned), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic v, logic [31:0] res, logic [31:0] wd, logic [3:0] be,
                              logic [4:0] rd, logic [2:0] f3, logic rw, logic mr, logic mw,
                              logic m2r, logic mis, logic rv, logic [31:0] rpc);
    exp_t e;
    e.v = v; e.res = res; e.wd = wd; e.be = be; e.rd = rd; e.f3 = f3;
    e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.mis = mis; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("mem_valid", 32'(mem_valid), 32'(e.v));
    chk("mem_result", mem_result, e.res);
    chk("mem_wdata", mem_wdata, e.wd);
    chk("mem_be", 32'(mem_be), 32'(e.be));
    chk("mem_rd", 32'(mem_rd), 32'(e.rd));
    chk("mem_funct3", 32'(mem_funct3), 32'(e.f3));
    chk("mem_reg_write", 32'(mem_reg_write), 32'(e.rw));
    chk("mem_mem_read", 32'(mem_mem_read), 32'(e.mr));
    chk("mem_mem_write", 32'(mem_mem_write), 32'(e.mw));
    chk("mem_mem_to_reg", 32'(mem_mem_to_reg), 32'(e.m2r));
    chk("mem_misaligned", 32'(mem_misaligned), 32'(e.mis));
    chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
    chk("redirect_pc", redirect_pc, e.rpc);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) compare(q.pop_front());
  end

  task automatic setin(logic v, logic [31:0] alu, logic [31:0] pc, logic [31:0] imm,
                       logic [31:0] rs1, logic [31:0] rs2, logic [4:0] rd, logic [2:0] f3,
                       logic br, logic jal, logic jalr, logic rw, logic mr, logic mw, logic m2r);
    ex_valid = v; alu_result = alu; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_rs2 = rs2;
    ex_rd = rd; ex_funct3 = f3; ex_branch = br; ex_jal = jal; ex_jalr = jalr;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  task automatic idle();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    q.push_back('0);
    // valid ADD, then asynchronous reset mid-cycle
    setin(1, 32'h10, 32'h40, 0, 0, 0, 5, 3'b000, 0, 0, 0, 1, 0, 0, 0);
    cyc(mk(1, 32'h10, 0, 4'b0001, 5, 0, 1, 0, 0, 0, 0, 0, 32'h40));
    idle();
    #6 reset = 1'b0;
    #1 compare('0);
    @(posedge clk);
    #1 reset = 1'b1;
    q.push_back('0);
    // BEQ taken, then held by stall: redirect only once
    setin(1, 32'h1, 32'h100, 32'h20, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    cyc(mk(1, 32'h1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1, 32'h120));
    stall = 1'b1;
    idle();
    repeat (3) cyc(mk(1, 32'h1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h120));
    stall = 1'b0;
    // JALR
    setin(1, 32'h1007, 32'h200, 32'h4, 32'h1003, 0, 1, 3'b000, 0, 0, 1, 1, 0, 0, 0);
    cyc(mk(1, 32'h204, 0, 4'b1000, 1, 0, 1, 0, 0, 0, 0, 1, 32'h1006));
    // invalid EX with controls set becomes a bubble
    setin(0, 32'h1, 32'h500, 32'h10, 0, 32'h55, 3, 3'b000, 1, 0, 0, 1, 0, 1, 0);
    cyc(mk(0, 32'h1, 32'h55555555, 4'b0010, 3, 0, 0, 0, 0, 0, 0, 0, 32'h510));
    // SB at lane 3
    setin(1, 32'h1003, 32'h300, 32'h3, 0, 32'hAABBCCDD, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    cyc(mk(1, 32'h1003, 32'hDDDDDDDD, 4'b1000, 0, 0, 0, 0, 1, 0, 0, 0, 32'h303));
    // SH misaligned
    setin(1, 32'h1001, 32'h304, 32'h1, 0, 32'hAABBCCDD, 0, 3'b001, 0, 0, 0, 0, 0, 1, 0);
    cyc(mk(1, 32'h1001, 32'hCCDDCCDD, 4'b0000, 0, 1, 0, 0, 0, 0, 1, 0, 32'h305));
    // LW aligned
    setin(1, 32'h2000, 32'h308, 0, 0, 32'h12345678, 7, 3'b010, 0, 0, 0, 1, 1, 0, 1);
    cyc(mk(1, 32'h2000, 32'h12345678, 4'b1111, 7, 2, 1, 1, 0, 1, 0, 0, 32'h308));
    // LW misaligned
    setin(1, 32'h2002, 32'h30C, 0, 0, 0, 8, 3'b010, 0, 0, 0, 1, 1, 0, 1);
    cyc(mk(1, 32'h2002, 0, 4'b0000, 8, 2, 1, 1, 0, 1, 1, 0, 32'h30C));
    // flush wins over stall with a valid store in EX
    flush = 1'b1; stall = 1'b1;
    setin(1, 32'h4000, 32'h400, 0, 0, 32'h11, 0, 3'b010, 0, 0, 0, 0, 0, 1, 0);
    cyc('0);
    flush = 1'b0; stall = 1'b0;
    // JAL with PC wrap
    setin(1, 0, 32'hFFFFFFFC, 32'h8, 0, 0, 1, 3'b000, 0, 1, 0, 1, 0, 0, 0);
    cyc(mk(1, 0, 0, 4'b0001, 1, 0, 1, 0, 0, 0, 0, 1, 32'h4));
    // branch not taken
    setin(1, 0, 32'h600, 32'h40, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 0);
    cyc(mk(1, 0, 0, 4'b0011, 0, 1, 0, 0, 0, 0, 0, 0, 32'h640));
    idle();
    cyc(mk(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
